sync_width_conv_fifo: RTL and testbench

Single-clock FIFO with independent write and read word widths. It packs or unpacks data between a producer bus of INPUT_WIDTH and a consumer bus of OUTPUT_WIDTH. The block sits between same-clock datapath stages that need buffering plus width conversion. It supports standard and first-word-fall-through (FWFT) read modes and a selectable sub-word ordering.

---
 rtl/sync_width_conv_fifo.sv | 166 ++++++++++++++++
 tb/tb_sync_width_conv_fifo.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/sync_width_conv_fifo.sv
// sync_width_conv_fifo
//   Single-clock FIFO that packs (narrow->wide) or unpacks (wide->narrow)
//   between a write bus of INPUT_WIDTH and a read bus of OUTPUT_WIDTH.
//   Storage is kept as rows of the wider width; pointers count narrow units
//   and carry one extra wrap bit.
//
// Ports
//   sys_clk        clock, rising edge
//   rst            asynchronous reset, active low
//   wr_en / din    write request and write word
//   rd_en          read request (STANDARD) / pop acknowledge (FWFT)
//   valid / dout   registered read word and its qualifier
//   full / empty   registered status flags
//   wr_data_count  whole write words stored
//   rd_data_count  whole read words stored
//   wr_data_space  whole write words free
//   rd_data_space  whole read words free
module sync_width_conv_fifo #(
    parameter int    INPUT_WIDTH  = 64,
    parameter int    OUTPUT_WIDTH = 8,
    parameter int    WR_DEPTH     = 16,
    parameter int    RD_DEPTH     = 128,
    parameter string MODE         = "FWFT",
    parameter string DIRECTION    = "LSB"
) (
    input  logic                      sys_clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [INPUT_WIDTH-1:0]    din,
    input  logic                      rd_en,
    output logic                      valid,
    output logic [OUTPUT_WIDTH-1:0]   dout,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(WR_DEPTH):0] wr_data_count,
    output logic [$clog2(RD_DEPTH):0] rd_data_count,
    output logic [$clog2(WR_DEPTH):0] wr_data_space,
    output logic [$clog2(RD_DEPTH):0] rd_data_space
);
    localparam int NW    = (INPUT_WIDTH < OUTPUT_WIDTH) ? INPUT_WIDTH : OUTPUT_WIDTH;
    localparam int WW    = (INPUT_WIDTH < OUTPUT_WIDTH) ? OUTPUT_WIDTH : INPUT_WIDTH;
    localparam int R     = WW / NW;
    localparam int RB    = $clog2(R);
    localparam int SW    = (RB > 0) ? RB : 1;
    localparam int UNITS = WR_DEPTH * (INPUT_WIDTH / NW);
    localparam int AW    = $clog2(UNITS);
    localparam int ROWS  = UNITS / R;
    localparam bit FWFT  = (MODE == "FWFT");
    localparam bit LSB   = (DIRECTION == "LSB");
    localparam bit UP    = (INPUT_WIDTH < OUTPUT_WIDTH);
    // log2 of narrow units per write word / per read word
    localparam int WSH   = UP ? 0 : RB;
    localparam int RSH   = UP ? RB : 0;
    localparam int WCW   = $clog2(WR_DEPTH) + 1;
    localparam int RCW   = $clog2(RD_DEPTH) + 1;
    localparam int UW    = 1 << WSH;
    localparam int UR    = 1 << RSH;
    localparam logic [AW:0] W_INC = UW[AW:0];
    localparam logic [AW:0] R_INC = UR[AW:0];
    localparam logic [AW:0] CAP   = UNITS[AW:0];

    // Row k slot holds the k-th narrow unit in FIFO order
    logic [R-1:0][NW-1:0] r_mem [ROWS];

    logic [AW:0]             r_wr_ptr, r_rd_ptr;
    logic                    r_valid, r_full, r_empty;
    logic [OUTPUT_WIDTH-1:0] r_dout;
    logic [WCW-1:0]          r_wr_cnt, r_wr_space;
    logic [RCW-1:0]          r_rd_cnt, r_rd_space;

    logic                    w_wr_acc, w_rd_acc, w_valid_nxt;
    logic [AW:0]             w_used, w_rd_addr;
    logic [AW:0]             w_wr_ptr_nxt, w_rd_ptr_nxt, w_used_nxt, w_free_nxt;
    logic [RCW-1:0]          w_rd_cnt;
    logic [OUTPUT_WIDTH-1:0] w_rd_word, w_dout_nxt;

    assign w_wr_acc     = wr_en & ~r_full;
    assign w_rd_acc     = rd_en & (FWFT ? r_valid : ~r_empty);
    assign w_used       = r_wr_ptr - r_rd_ptr;
    assign w_rd_cnt     = w_used[AW:RSH];
    // On an FWFT pop the word after the head is fetched so that the
    // output register refills on the same edge (no bubble).
    assign w_rd_addr    = (FWFT && w_rd_acc) ? (r_rd_ptr + R_INC) : r_rd_ptr;
    assign w_wr_ptr_nxt = r_wr_ptr + (w_wr_acc ? W_INC : '0);
    assign w_rd_ptr_nxt = r_rd_ptr + (w_rd_acc ? R_INC : '0);
    assign w_used_nxt   = w_wr_ptr_nxt - w_rd_ptr_nxt;
    assign w_free_nxt   = CAP - w_used_nxt;

    generate
        if (!UP) begin : g_down
            logic [R-1:0][NW-1:0] w_din_row;
            logic [SW-1:0]        w_rd_slice;
            always_comb begin
                for (int k = 0; k < R; k++)
                    w_din_row[k] = din[(LSB ? k : R-1-k)*NW +: NW];
            end
            assign w_rd_slice = SW'(w_rd_addr % R);
            always_ff @(posedge sys_clk) begin
                if (w_wr_acc) r_mem[r_wr_ptr[AW-1:RB]] <= w_din_row;
            end
            assign w_rd_word = r_mem[w_rd_addr[AW-1:RB]][w_rd_slice];
        end else begin : g_up
            logic [R-1:0][NW-1:0] w_rd_row;
            always_ff @(posedge sys_clk) begin
                if (w_wr_acc) r_mem[r_wr_ptr[AW-1:RB]][r_wr_ptr[RB-1:0]] <= din;
            end
            assign w_rd_row = r_mem[w_rd_addr[AW-1:RB]];
            always_comb begin
                for (int k = 0; k < R; k++)
                    w_rd_word[k*NW +: NW] = w_rd_row[LSB ? k : R-1-k];
            end
        end
    endgenerate

    always_comb begin
        w_valid_nxt = r_valid;
        w_dout_nxt  = r_dout;
        if (FWFT) begin
            // Refill the output register when it is empty or being popped;
            // a pop needs a second complete word behind the head.
            if (!r_valid || w_rd_acc) begin
                w_valid_nxt = w_rd_acc ? (w_rd_cnt >= RCW'(2)) : (w_rd_cnt != '0);
                if (w_valid_nxt) w_dout_nxt = w_rd_word;
            end
        end else begin
            w_valid_nxt = w_rd_acc;
            if (w_rd_acc) w_dout_nxt = w_rd_word;
        end
    end

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_valid    <= 1'b0;
            r_dout     <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_wr_cnt   <= '0;
            r_rd_cnt   <= '0;
            r_wr_space <= WCW'(WR_DEPTH);
            r_rd_space <= RCW'(RD_DEPTH);
        end else begin
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_rd_ptr   <= w_rd_ptr_nxt;
            r_valid    <= w_valid_nxt;
            r_dout     <= w_dout_nxt;
            r_wr_cnt   <= w_used_nxt[AW:WSH];
            r_rd_cnt   <= w_used_nxt[AW:RSH];
            r_wr_space <= w_free_nxt[AW:WSH];
            r_rd_space <= w_free_nxt[AW:RSH];
            r_full     <= (w_free_nxt[AW:WSH] == '0);
            r_empty    <= FWFT ? ~w_valid_nxt : (w_used_nxt[AW:RSH] == '0);
        end
    end

    assign valid         = r_valid;
    assign dout          = r_dout;
    assign full          = r_full;
    assign empty         = r_empty;
    assign wr_data_count = r_wr_cnt;
    assign rd_data_count = r_rd_cnt;
    assign wr_data_space = r_wr_space;
    assign rd_data_space = r_rd_space;

endmodule

// File: tb/tb_sync_width_conv_fifo.sv
// Directed bench for sync_width_conv_fifo: four instances cover the default
// 64->8 FWFT/LSB build, MSB ordering, STANDARD mode and 8->64 packing.
module tb_sync_width_conv_fifo;
    localparam logic [63:0] BASE = 64'h0123456789abcdef;
    localparam logic [63:0] INC  = 64'h0101010101010101;

    logic sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int n_vec = 0;
    int n_err = 0;

    // a: default, b: MSB, c: STANDARD
    logic        rst_a, we_a, re_a, v_a, f_a, e_a;
    logic [63:0] din_a;
    logic [7:0]  do_a, rc_a, rs_a;
    logic [4:0]  wc_a, ws_a;
    logic        rst_b, we_b, re_b, v_b, f_b, e_b;
    logic [63:0] din_b;
    logic [7:0]  do_b, rc_b, rs_b;
    logic [4:0]  wc_b, ws_b;
    logic        rst_c, we_c, re_c, v_c, f_c, e_c;
    logic [63:0] din_c;
    logic [7:0]  do_c, rc_c, rs_c;
    logic [4:0]  wc_c, ws_c;
    // d: 8 -> 64
    logic        rst_d, we_d, re_d, v_d, f_d, e_d;
    logic [7:0]  din_d, wc_d, ws_d;
    logic [63:0] do_d;
    logic [4:0]  rc_d, rs_d;

    sync_width_conv_fifo u_a (
        .sys_clk(sys_clk), .rst(rst_a), .wr_en(we_a), .din(din_a), .rd_en(re_a),
        .valid(v_a), .dout(do_a), .full(f_a), .empty(e_a),
        .wr_data_count(wc_a), .rd_data_count(rc_a),
        .wr_data_space(ws_a), .rd_data_space(rs_a));

    sync_width_conv_fifo #(.DIRECTION("MSB")) u_b (
        .sys_clk(sys_clk), .rst(rst_b), .wr_en(we_b), .din(din_b), .rd_en(re_b),
        .valid(v_b), .dout(do_b), .full(f_b), .empty(e_b),
        .wr_data_count(wc_b), .rd_data_count(rc_b),
        .wr_data_space(ws_b), .rd_data_space(rs_b));

    sync_width_conv_fifo #(.MODE("STANDARD")) u_c (
        .sys_clk(sys_clk), .rst(rst_c), .wr_en(we_c), .din(din_c), .rd_en(re_c),
        .valid(v_c), .dout(do_c), .full(f_c), .empty(e_c),
        .wr_data_count(wc_c), .rd_data_count(rc_c),
        .wr_data_space(ws_c), .rd_data_space(rs_c));

    sync_width_conv_fifo #(.INPUT_WIDTH(8), .OUTPUT_WIDTH(64),
                           .WR_DEPTH(128), .RD_DEPTH(16)) u_d (
        .sys_clk(sys_clk), .rst(rst_d), .wr_en(we_d), .din(din_d), .rd_en(re_d),
        .valid(v_d), .dout(do_d), .full(f_d), .empty(e_d),
        .wr_data_count(wc_d), .rd_data_count(rc_d),
        .wr_data_space(ws_d), .rd_data_space(rs_d));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge sys_clk);
        #1;
    endtask

    // j-th byte read out of the fill sequence (LSB-first unpacking)
    function automatic logic [7:0] fill_byte(input int j);
        logic [63:0] w;
        w = BASE + 64'(j / 8) * INC;
        return w[(j % 8)*8 +: 8];
    endfunction

    initial begin
        logic [63:0] msb_word;
        rst_a = 1; rst_b = 1; rst_c = 1; rst_d = 1;
        we_a = 0; re_a = 0; din_a = '0;
        we_b = 0; re_b = 0; din_b = '0;
        we_c = 0; re_c = 0; din_c = '0;
        we_d = 0; re_d = 0; din_d = '0;
        #1;
        rst_a = 0; rst_b = 0; rst_c = 0; rst_d = 0;
        #2;
        chk("a_rst_valid", 64'(v_a), 64'(0));
        chk("a_rst_dout",  64'(do_a), 64'(0));
        chk("a_rst_full",  64'(f_a), 64'(0));
        chk("a_rst_empty", 64'(e_a), 64'(1));
        chk("a_rst_wcnt",  64'(wc_a), 64'(0));
        chk("a_rst_rcnt",  64'(rc_a), 64'(0));
        chk("a_rst_wspace", 64'(ws_a), 64'(16));
        chk("a_rst_rspace", 64'(rs_a), 64'(128));
        chk("d_rst_wspace", 64'(ws_d), 64'(128));
        chk("d_rst_rspace", 64'(rs_d), 64'(16));
        @(negedge sys_clk);
        rst_a = 1; rst_b = 1; rst_c = 1; rst_d = 1;

        // ---- a: fill with 17 writes, 17th must be dropped ----
        we_a = 1;
        for (int i = 0; i < 17; i++) begin
            din_a = BASE + 64'(i) * INC;
            tick;
            if (i == 0) begin
                chk("a_w1_valid", 64'(v_a), 64'(0));
                chk("a_w1_rcnt",  64'(rc_a), 64'(8));
                chk("a_w1_wcnt",  64'(wc_a), 64'(1));
            end
            if (i == 1) begin
                chk("a_pref_valid", 64'(v_a), 64'(1));
                chk("a_pref_dout",  64'(do_a), 64'(8'hef));
                chk("a_pref_empty", 64'(e_a), 64'(0));
            end
            if (i == 15) begin
                chk("a_full",   64'(f_a), 64'(1));
                chk("a_f_wcnt", 64'(wc_a), 64'(16));
                chk("a_f_rcnt", 64'(rc_a), 64'(128));
                chk("a_f_wsp",  64'(ws_a), 64'(0));
            end
        end
        chk("a_w17_wcnt", 64'(wc_a), 64'(16));
        chk("a_w17_full", 64'(f_a), 64'(1));

        // ---- a: drain with rd_en held ----
        we_a = 0;
        re_a = 1;
        for (int j = 0; j < 128; j++) begin
            if (j == 1) chk("a_pop1_full", 64'(f_a), 64'(1));
            if (j == 8) begin
                chk("a_pop8_full", 64'(f_a), 64'(0));
                chk("a_pop8_wsp",  64'(ws_a), 64'(1));
            end
            chk($sformatf("a_word%0d", j), 64'({v_a, do_a}), 64'({1'b1, fill_byte(j)}));
            tick;
        end
        chk("a_drained_valid", 64'(v_a), 64'(0));
        chk("a_drained_empty", 64'(e_a), 64'(1));
        chk("a_drained_rsp",   64'(rs_a), 64'(128));
        chk("a_drained_rcnt",  64'(rc_a), 64'(0));
        chk("a_drained_wsp",   64'(ws_a), 64'(16));
        tick; tick; tick;
        chk("a_rdempty_valid", 64'(v_a), 64'(0));
        chk("a_rdempty_empty", 64'(e_a), 64'(1));
        chk("a_rdempty_rcnt",  64'(rc_a), 64'(0));
        re_a = 0;

        // ---- b: MSB ordering ----
        we_b = 1;
        din_b = BASE;
        tick;
        we_b = 0;
        chk("b_w1_valid", 64'(v_b), 64'(0));
        tick;
        re_b = 1;
        msb_word = BASE;
        for (int j = 0; j < 8; j++) begin
            chk($sformatf("b_word%0d", j), 64'({v_b, do_b}), 64'({1'b1, msb_word[(7-j)*8 +: 8]}));
            tick;
        end
        chk("b_end_valid", 64'(v_b), 64'(0));
        chk("b_end_empty", 64'(e_b), 64'(1));
        re_b = 0;

        // ---- c: STANDARD mode ----
        we_c = 1;
        for (int i = 0; i < 8; i++) begin
            din_c = BASE + 64'(i) * INC;
            tick;
        end
        chk("c_half_wcnt",  64'(wc_c), 64'(8));
        chk("c_half_rcnt",  64'(rc_c), 64'(64));
        chk("c_half_empty", 64'(e_c), 64'(0));
        chk("c_half_valid", 64'(v_c), 64'(0));
        // simultaneous write (+8 units) and read (-1 unit)
        din_c = BASE + 64'(8) * INC;
        re_c = 1;
        tick;
        we_c = 0;
        re_c = 0;
        chk("c_wr_rd_valid", 64'(v_c), 64'(1));
        chk("c_wr_rd_dout",  64'(do_c), 64'(8'hef));
        chk("c_wr_rd_rcnt",  64'(rc_c), 64'(71));
        chk("c_wr_rd_wcnt",  64'(wc_c), 64'(8));
        chk("c_wr_rd_wsp",   64'(ws_c), 64'(7));
        chk("c_wr_rd_rsp",   64'(rs_c), 64'(57));
        re_c = 1;
        tick;
        re_c = 0;
        chk("c_rd2", 64'({v_c, do_c}), 64'({1'b1, 8'hcd}));
        chk("c_rd2_rcnt", 64'(rc_c), 64'(70));
        tick;
        chk("c_idle", 64'({v_c, do_c}), 64'({1'b0, 8'hcd}));

        // ---- d: 8 -> 64 packing and async reset ----
        we_d = 1;
        for (int i = 0; i < 8; i++) begin
            din_d = 8'(17 * (i + 1));
            tick;
            if (i == 6) begin
                chk("d_w7_rcnt",  64'(rc_d), 64'(0));
                chk("d_w7_empty", 64'(e_d), 64'(1));
                chk("d_w7_wcnt",  64'(wc_d), 64'(7));
            end
        end
        we_d = 0;
        chk("d_w8_rcnt",  64'(rc_d), 64'(1));
        chk("d_w8_wcnt",  64'(wc_d), 64'(8));
        chk("d_w8_valid", 64'(v_d), 64'(0));
        tick;
        chk("d_word", 64'({v_d, do_d} >> 0), 64'h8877665544332211);
        chk("d_word_valid", 64'(v_d), 64'(1));
        we_d = 1;
        for (int i = 0; i < 3; i++) begin
            din_d = 8'(8'h99 + 17 * i);
            tick;
        end
        we_d = 0;
        #2;
        rst_d = 0;
        #1;
        chk("d_arst_valid", 64'(v_d), 64'(0));
        chk("d_arst_dout",  do_d, 64'(0));
        chk("d_arst_wcnt",  64'(wc_d), 64'(0));
        chk("d_arst_rcnt",  64'(rc_d), 64'(0));
        chk("d_arst_empty", 64'(e_d), 64'(1));
        chk("d_arst_full",  64'(f_d), 64'(0));
        chk("d_arst_wsp",   64'(ws_d), 64'(128));
        chk("d_arst_rsp",   64'(rs_d), 64'(16));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
